vend_sequencer: RTL and testbench

Control FSM for the retro vending datapath. It accepts coin pulses, keeps a running credit, and arbitrates a 4-product selection against a fixed price table. It issues a one-cycle dispense strobe, then sequences greedy change return one coin per cycle. It replaces the single-product select/dispense path, and credit is visible to top level for display.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_edge_arb.sv | 63 ++++++
 rtl/vend_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
//   state_t  : sequencer FSM states
//   C5/C10/C25 : coin values in cents
//   PRICE    : product price table in cents, indexed by product number
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int C5  = 5;
  localparam int C10 = 10;
  localparam int C25 = 25;

  localparam int PRICE [4] = '{50, 35, 25, 65};

  function automatic int price_of(input logic [1:0] p);
    return PRICE[p];
  endfunction

endpackage

// File: rtl/vend_edge_arb.sv
// Input capture, rising-edge detection and coin arbitration.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   coin_5/10/25, select,
//   cancel, product            : raw input levels
//   coin_val                   : value of the winning coin edge this cycle (0 = none)
//   coin_lost                  : more than one coin edge this cycle
//   sel_edge, cancel_edge      : rising edges of select / cancel
//   product_q                  : product index registered alongside select
module vend_edge_arb
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       coin_25,
  input  logic       select,
  input  logic [1:0] product,
  input  logic       cancel,
  output logic [4:0] coin_val,
  output logic       coin_lost,
  output logic       sel_edge,
  output logic       cancel_edge,
  output logic [1:0] product_q
);

  // bit order: {coin_25, coin_10, coin_5, select, cancel}
  logic [4:0] lvl;
  logic [4:0] cur;
  logic [4:0] prev;
  logic [4:0] rise;

  assign lvl = {coin_25, coin_10, coin_5, select, cancel};

  // Both history stages load the live levels during reset so that a level
  // already high at release is never seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur       <= lvl;
      prev      <= lvl;
      product_q <= product;
    end else begin
      cur       <= lvl;
      prev      <= cur;
      product_q <= product;
    end
  end

  assign rise        = cur & ~prev;
  assign sel_edge    = rise[1];
  assign cancel_edge = rise[0];

  always_comb begin
    coin_val = '0;
    if (rise[4])      coin_val = 5'(C25);
    else if (rise[3]) coin_val = 5'(C10);
    else if (rise[2]) coin_val = 5'(C5);
  end

  assign coin_lost = (rise[4] & (rise[3] | rise[2])) | (rise[3] & rise[2]);

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: credit accumulation, product purchase and greedy
// change return.
// Ports:
//   clk, reset              : clock, synchronous active-low reset
//   coin_5/10/25            : coin sensor levels (rising edge = coin)
//   select, product         : purchase request and product index
//   cancel                  : refund request
//   credit                  : current credit in cents
//   dispense, dispense_id   : one-cycle purchase strobe and product
//   change_25/10/5          : one-cycle coin-return pulses
//   coin_reject             : coin edge seen but not credited
//   short_funds             : select with insufficient credit
//   busy                    : dispensing or returning change
//
// state    | meaning
// IDLE     | no credit; waiting for first coin
// CREDIT   | credit held; accepting coins, select, cancel, timeout
// DISPENSE | one cycle; purchase strobe out, price deducted
// CHANGE   | returning remaining credit one coin per cycle
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W       = 8,
  parameter int MAX_CREDIT     = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                coin_25,
  input  logic                select,
  input  logic [1:0]          product,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [1:0]          dispense_id,
  output logic                change_25,
  output logic                change_10,
  output logic                change_5,
  output logic                coin_reject,
  output logic                short_funds,
  output logic                busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [4:0] coin_val;
  logic       coin_lost;
  logic       sel_edge;
  logic       cancel_edge;
  logic [1:0] product_q;

  vend_edge_arb u_edge_arb (
    .clk         (clk),
    .reset       (reset),
    .coin_5      (coin_5),
    .coin_10     (coin_10),
    .coin_25     (coin_25),
    .select      (select),
    .product     (product),
    .cancel      (cancel),
    .coin_val    (coin_val),
    .coin_lost   (coin_lost),
    .sel_edge    (sel_edge),
    .cancel_edge (cancel_edge),
    .product_q   (product_q)
  );

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                dispense_nxt;
  logic [1:0]          dispense_id_nxt;
  logic                change_25_nxt, change_10_nxt, change_5_nxt;
  logic                coin_reject_nxt, short_funds_nxt, busy_nxt;

  logic                coin_any;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] disp_price;

  assign coin_any   = (coin_val != '0);
  // one extra bit so the ceiling check cannot wrap
  assign coin_sum   = {1'b0, credit} + (CREDIT_W + 1)'(coin_val);
  assign coin_fits  = (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT));
  assign sel_price  = CREDIT_W'(price_of(product_q));
  // dispense_id still holds the purchased product during DISPENSE
  assign disp_price = CREDIT_W'(price_of(dispense_id));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      credit      <= '0;
      dispense    <= 1'b0;
      dispense_id <= '0;
      change_25   <= 1'b0;
      change_10   <= 1'b0;
      change_5    <= 1'b0;
      coin_reject <= 1'b0;
      short_funds <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      credit      <= credit_nxt;
      dispense    <= dispense_nxt;
      dispense_id <= dispense_id_nxt;
      change_25   <= change_25_nxt;
      change_10   <= change_10_nxt;
      change_5    <= change_5_nxt;
      coin_reject <= coin_reject_nxt;
      short_funds <= short_funds_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    credit_nxt      = credit;
    dispense_nxt    = 1'b0;
    dispense_id_nxt = '0;
    change_25_nxt   = 1'b0;
    change_10_nxt   = 1'b0;
    change_5_nxt    = 1'b0;
    coin_reject_nxt = 1'b0;
    short_funds_nxt = 1'b0;

    case (state)
      IDLE: begin
        short_funds_nxt = sel_edge;
        if (coin_any) begin
          if (coin_fits) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            timer_nxt  = '0;
            state_nxt  = CREDIT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
          if (coin_lost) coin_reject_nxt = 1'b1;
        end
      end

      CREDIT: begin
        if (sel_edge) begin
          if (credit >= sel_price) begin
            dispense_nxt    = 1'b1;
            dispense_id_nxt = product_q;
            state_nxt       = DISPENSE;
          end else begin
            short_funds_nxt = 1'b1;
            timer_nxt       = '0;
          end
          coin_reject_nxt = coin_any;
        end else if (cancel_edge) begin
          state_nxt       = CHANGE;
          coin_reject_nxt = coin_any;
        end else if (coin_any) begin
          if (coin_fits) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            timer_nxt  = '0;
          end else begin
            coin_reject_nxt = 1'b1;
          end
          if (coin_lost) coin_reject_nxt = 1'b1;
        end else if (timer == TMR_LAST) begin
          state_nxt = CHANGE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      DISPENSE: begin
        timer_nxt       = '0;
        credit_nxt      = credit - disp_price;
        state_nxt       = (credit_nxt != '0) ? CHANGE : IDLE;
        coin_reject_nxt = coin_any;
      end

      CHANGE: begin
        timer_nxt       = '0;
        coin_reject_nxt = coin_any;
        if (credit >= CREDIT_W'(C25)) begin
          change_25_nxt = 1'b1;
          credit_nxt    = credit - CREDIT_W'(C25);
        end else if (credit >= CREDIT_W'(C10)) begin
          change_10_nxt = 1'b1;
          credit_nxt    = credit - CREDIT_W'(C10);
        end else if (credit != '0) begin
          change_5_nxt  = 1'b1;
          credit_nxt    = credit - CREDIT_W'(C5);
        end
        if (credit_nxt == '0) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == DISPENSE) || (state_nxt == CHANGE);
  end

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

  localparam int MAXC = 100;
  localparam int TMO  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_5 = 1'b0, coin_10 = 1'b0, coin_25 = 1'b1;
  logic       select = 1'b0, cancel = 1'b0;
  logic [1:0] product = '0;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_25, change_10, change_5;
  logic       coin_reject, short_funds, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vend_sequencer #(.CREDIT_W(8), .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .coin_5(coin_5), .coin_10(coin_10), .coin_25(coin_25),
    .select(select), .product(product), .cancel(cancel),
    .credit(credit), .dispense(dispense), .dispense_id(dispense_id),
    .change_25(change_25), .change_10(change_10), .change_5(change_5),
    .coin_reject(coin_reject), .short_funds(short_funds), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int price_tab [4] = '{50, 35, 25, 65};
  int m_credit = 0, m_idle = 0, m_price = 0;
  bit m_disp = 0;
  int refund_q[$];
  logic [4:0] h_prev, h_cur, lv, e;
  logic [1:0] h_prod;
  bit armed = 0;
  int e_credit, e_id, n, best, c;
  bit e_disp, e_c25, e_c10, e_c5, e_rej, e_sf, e_busy;

  task automatic fill_refund(input int amount);
    int a;
    a = amount;
    while (a > 0) begin
      if (a >= 25) begin refund_q.push_back(25); a -= 25; end
      else if (a >= 10) begin refund_q.push_back(10); a -= 10; end
      else begin refund_q.push_back(5); a -= 5; end
    end
  endtask

  always @(posedge clk) begin
    lv = {coin_25, coin_10, coin_5, select, cancel};
    e_disp = 0; e_id = 0; e_c25 = 0; e_c10 = 0; e_c5 = 0; e_rej = 0; e_sf = 0;
    if (!reset) begin
      m_credit = 0; m_idle = 0; m_disp = 0; refund_q.delete();
      h_prev = lv; h_cur = lv; h_prod = product;
      armed = 1;
    end else begin
      e = h_cur & ~h_prev;
      n = int'(e[4]) + int'(e[3]) + int'(e[2]);
      best = e[4] ? 25 : (e[3] ? 10 : (e[2] ? 5 : 0));
      if (m_disp) begin
        m_credit -= m_price;
        fill_refund(m_credit);
        m_disp = 0;
        e_rej = (n > 0);
      end else if (refund_q.size() > 0) begin
        c = refund_q.pop_front();
        e_c25 = (c == 25); e_c10 = (c == 10); e_c5 = (c == 5);
        m_credit -= c;
        e_rej = (n > 0);
      end else if (m_credit == 0) begin
        e_sf = e[1];
        if (n > 0) begin
          if (m_credit + best <= MAXC) begin m_credit += best; m_idle = 0; end
          else e_rej = 1;
          if (n > 1) e_rej = 1;
        end
      end else if (e[1]) begin
        if (m_credit >= price_tab[h_prod]) begin
          e_disp = 1; e_id = int'(h_prod); m_disp = 1; m_price = price_tab[h_prod]; m_idle = 0;
        end else begin
          e_sf = 1; m_idle = 0;
        end
        e_rej = (n > 0);
      end else if (e[0]) begin
        fill_refund(m_credit); m_idle = 0;
        e_rej = (n > 0);
      end else if (n > 0) begin
        if (m_credit + best <= MAXC) begin m_credit += best; m_idle = 0; end
        else e_rej = 1;
        if (n > 1) e_rej = 1;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin fill_refund(m_credit); m_idle = 0; end
      end
      h_prev = h_cur; h_cur = lv; h_prod = product;
    end
    e_credit = m_credit;
    e_busy = m_disp || (refund_q.size() > 0);
    #1;
    if (armed) begin
      chk("credit", int'(credit), e_credit);
      chk("dispense", int'(dispense), int'(e_disp));
      if (e_disp) chk("dispense_id", int'(dispense_id), e_id);
      chk("change_25", int'(change_25), int'(e_c25));
      chk("change_10", int'(change_10), int'(e_c10));
      chk("change_5", int'(change_5), int'(e_c5));
      chk("coin_reject", int'(coin_reject), int'(e_rej));
      chk("short_funds", int'(short_funds), int'(e_sf));
      chk("busy", int'(busy), int'(e_busy));
    end
  end

  // ---------------- stimulus ----------------
  // bit order of m: {coin_25, coin_10, coin_5, select, cancel}
  task automatic pulse(input logic [4:0] m, input logic [1:0] p);
    {coin_25, coin_10, coin_5, select, cancel} = m;
    product = p;
    @(negedge clk);
    {coin_25, coin_10, coin_5, select, cancel} = 5'b0;
    @(negedge clk);
  endtask

  localparam logic [4:0] K25 = 5'b10000, K10 = 5'b01000, K5 = 5'b00100;
  localparam logic [4:0] KSEL = 5'b00010, KCAN = 5'b00001;

  initial begin
    int cnt;
    // reset with a quarter level held high across release
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("lvl_at_release_credit", int'(credit), 0);
    chk("lvl_at_release_reject", int'(coin_reject), 0);
    chk("lvl_at_release_busy", int'(busy), 0);
    coin_25 = 1'b0;
    @(negedge clk);

    // exact purchase
    pulse(K25, 0); chk("c25_credit", int'(credit), 25);
    pulse(K25, 0); chk("c50_credit", int'(credit), 50);
    pulse(KSEL, 0);
    chk("buy0_dispense", int'(dispense), 1);
    chk("buy0_id", int'(dispense_id), 0);
    @(negedge clk);
    chk("buy0_strobe_end", int'(dispense), 0);
    chk("buy0_credit", int'(credit), 0);
    chk("buy0_busy", int'(busy), 0);

    // purchase with change 40 -> 25,10,5
    pulse(K25, 0); pulse(K25, 0); pulse(K25, 0);
    pulse(KSEL, 1);
    chk("buy1_dispense", int'(dispense), 1);
    chk("buy1_id", int'(dispense_id), 1);
    @(negedge clk); chk("buy1_left", int'(credit), 40);
    @(negedge clk); chk("chg_q", int'(change_25), 1); chk("chg_q_credit", int'(credit), 15);
    @(negedge clk); chk("chg_d", int'(change_10), 1); chk("chg_d_credit", int'(credit), 5);
    @(negedge clk); chk("chg_n", int'(change_5), 1); chk("chg_n_credit", int'(credit), 0);
    chk("chg_done_busy", int'(busy), 0);

    // simultaneous coins, then ceiling
    pulse(K25 | K10, 0);
    chk("dual_credit", int'(credit), 25);
    chk("dual_reject", int'(coin_reject), 1);
    @(negedge clk); chk("dual_reject_end", int'(coin_reject), 0);
    pulse(K25, 0); pulse(K25, 0); pulse(K25, 0);
    chk("full_credit", int'(credit), 100);
    pulse(K5, 0);
    chk("over_reject", int'(coin_reject), 1);
    chk("over_credit", int'(credit), 100);
    pulse(KCAN, 0);
    repeat (5) @(negedge clk);
    chk("drain_credit", int'(credit), 0);

    // short funds, cancel, timeout
    pulse(K10, 0);
    pulse(KSEL, 2);
    chk("short_pulse", int'(short_funds), 1);
    chk("short_credit", int'(credit), 10);
    pulse(KCAN, 0);
    chk("cancel_busy", int'(busy), 1);
    @(negedge clk);
    chk("cancel_c10", int'(change_10), 1);
    chk("cancel_credit", int'(credit), 0);
    @(negedge clk);
    pulse(K10, 0); pulse(K5, 0);
    chk("tmo_credit", int'(credit), 15);
    cnt = 0;
    while (change_10 == 1'b0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("tmo_latency", cnt, TMO + 1);
    chk("tmo_c10", int'(change_10), 1);
    @(negedge clk);
    chk("tmo_c5", int'(change_5), 1);
    chk("tmo_credit_end", int'(credit), 0);

    // coin during change, then reset during change
    pulse(K25, 0); pulse(K10, 0); pulse(K5, 0);
    pulse(KCAN, 0);
    pulse(K5, 0);
    chk("busy_coin_reject", int'(coin_reject), 1);
    chk("busy_coin_c10", int'(change_10), 1);
    chk("busy_coin_credit", int'(credit), 5);
    @(negedge clk);
    chk("busy_coin_c5", int'(change_5), 1);
    chk("busy_coin_end", int'(credit), 0);
    pulse(K25, 0); pulse(K25, 0); pulse(K25, 0);
    pulse(KCAN, 0);
    @(negedge clk);
    chk("pre_rst_c25", int'(change_25), 1);
    chk("pre_rst_credit", int'(credit), 50);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_credit", int'(credit), 0);

    // randomized traffic with quiet stretches for the timeout path
    for (int i = 0; i < 4000; i++) begin
      if ((i % 600) < 60) begin
        {coin_25, coin_10, coin_5, select, cancel} = 5'b0;
        reset = 1'b1;
      end else begin
        coin_25 = ($urandom_range(0, 9) == 0);
        coin_10 = ($urandom_range(0, 9) == 0);
        coin_5  = ($urandom_range(0, 9) == 0);
        select  = ($urandom_range(0, 11) == 0);
        cancel  = ($urandom_range(0, 29) == 0);
        product = 2'($urandom_range(0, 3));
        reset   = ($urandom_range(0, 499) != 0);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    {coin_25, coin_10, coin_5, select, cancel} = 5'b0;
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
